// File: rtl/mod_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mod_arith_pkg
//  Brief    : Shared types for the modular-arithmetic datapath (operand stage
//             and reducer): operation encoding, stage state encoding and a
//             result-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package mod_arith_pkg;

    // Operation select carried on the op input of the operand stage
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_ADD = 1'b1
    } op_e;

    // Operand stage sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } stage_state_e;

    // Result width that holds both a full product and a carry-out sum
    function automatic int result_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage : mod_arith_pkg
`default_nettype wire

// File: rtl/mul_add_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mul_add_stage
//  Brief    : Sequential operand stage. Multiplies two unsigned operands with a
//             shift-add loop (one multiplier bit per cycle, fixed latency) or
//             adds them in a single cycle, then presents the wide result with
//             a one-cycle start pulse for the downstream reducer.
//  Revision : 1.0  initial release
// ============================================================================
module mul_add_stage
    import mod_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op,
    input  logic [DATA_WIDTH-1:0]   x,
    input  logic [DATA_WIDTH-1:0]   y,
    output logic [2*DATA_WIDTH:0]   result,
    output logic                    mod_start,
    output logic                    busy,
    output logic                    done
);

    localparam int                 c_RES_W = result_width(DATA_WIDTH);
    localparam int                 c_CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    stage_state_e              r_state;
    logic [DATA_WIDTH-1:0]     r_x;
    logic [DATA_WIDTH-1:0]     r_y;
    logic [c_CNT_W-1:0]        r_count;
    logic [c_RES_W-1:0]        r_acc;
    logic                      r_ready;
    logic                      r_busy;
    logic                      r_done;

    logic [c_RES_W-1:0]        w_addend;
    logic [c_RES_W-1:0]        w_mul_sum;
    logic [c_RES_W-1:0]        w_add_result;

    // Partial product for the current multiplier bit, and the one-cycle sum path
    always_comb begin
        w_addend     = c_RES_W'(r_x) << r_count;
        w_mul_sum    = r_acc + w_addend;
        w_add_result = c_RES_W'(x) + c_RES_W'(y);
    end

    // Stage sequencer; status flags are registered alongside the state so the
    // outputs change only on the clock edge that changes the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (in_valid && r_ready) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_count <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (op_e'(op) == OP_ADD) begin
                            r_acc   <= w_add_result;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_acc   <= '0;
                            r_state <= MUL;
                        end
                    end
                end
                MUL: begin
                    // No early exit on a zero multiplier: latency is fixed
                    if (r_y[0]) begin
                        r_acc <= w_mul_sum;
                    end
                    r_y     <= r_y >> 1;
                    r_count <= r_count + c_ONE;
                    if (r_count == c_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // Accumulator is left untouched so the reducer samples a
                    // stable value on the edge that ends this cycle
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign mod_start = r_done;
    assign result    = r_acc;

endmodule : mul_add_stage
`default_nettype wire

// File: doc/mul_add_stage.md
# mul_add_stage

Sequential operand stage feeding the modular-reduction block: accepts two DATA_WIDTH-bit operands, computes either their product (shift-add, one multiplier bit per cycle) or their sum, and presents the (2·DATA_WIDTH+1)-bit result together with a one-cycle start pulse. The result bus connects directly to the reducer's dividend input and the pulse to its start input. The parent instantiates both blocks side by side.

## Interface
- DATA_WIDTH, 8, operand width; result width is 2·DATA_WIDTH+1
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operands and op valid this cycle
- in_ready  out  1  block can accept (high only in IDLE)
- op  in  1  0 = multiply, 1 = add
- x  in  DATA_WIDTH  operand / multiplicand, unsigned
- y  in  DATA_WIDTH  operand / multiplier, unsigned
- result  out  2·DATA_WIDTH+1  registered result; stable from DONE until next accept
- mod_start  out  1  one-cycle pulse; result is valid in the same cycle
- busy  out  1  high in MUL and DONE
- done  out  1  one-cycle pulse, identical timing to mod_start

## Operation
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - Latch x, y; clear the count.
    - op=0: clear the accumulator and go to MUL.
    - op=1: load the accumulator with zero-extended x+y and go to DONE.
- MUL:
  - Runs exactly DATA_WIDTH cycles; the latency is fixed with no early exit on y=0.
  - Each cycle: if the current multiplier LSB is 1, add the multiplicand shifted by the count into the accumulator.
  - Each cycle: shift the multiplier right and increment the count.
  - After the cycle with count = DATA_WIDTH−1, go to DONE.
- DONE:
  - mod_start=1, done=1, result = accumulator.
  - Next state is unconditionally IDLE.
- Width rules:
  - All arithmetic is unsigned.
  - The maximum product (2^W−1)^2 fits in 2W bits, so result[2W] is always 0 for multiply.
  - The maximum sum 2^(W+1)−2 uses at most bit W.
  - No overflow is possible; no truncation is permitted.
- in_valid outside IDLE is ignored: in_ready is low and the operands are not sampled.
- The result register holds its value through IDLE. It updates only on the next accept, or on the accumulation in MUL.

## Timing
- Cycle 0 is the cycle in which in_valid & in_ready = 1.
- Multiply:
  - Cycles 1..DATA_WIDTH in MUL.
  - Cycle DATA_WIDTH+1 in DONE (mod_start/done high).
  - Cycle DATA_WIDTH+2 in IDLE, in_ready=1.
- Add: cycle 1 in DONE, cycle 2 in IDLE.
- The reducer samples result on the clock edge ending the DONE cycle. The result must not change on that edge.
- Reset values: state IDLE, in_ready=1, busy=0, mod_start=0, done=0, result=0, count=0.
- Reset mid-MUL or in DONE:
  - Next cycle the block is in IDLE with all outputs at their reset values.
  - No mod_start is emitted for the aborted operation.
- Reset asserted together with in_valid: reset wins and nothing is accepted.
- Back-to-back: with in_valid held high, a new operation is accepted in every IDLE cycle. Throughput is one multiply per DATA_WIDTH+2 cycles and one add per 2 cycles.

## Structure
- Shared package mod_arith_pkg holds:
  - the op encoding enum (OP_MUL=0, OP_ADD=1);
  - the stage state enum {IDLE, MUL, DONE}.
- The reducer uses the same package for its own state type.
- There is no sub-module: the adder/shifter datapath is inline.
- The count is $clog2(DATA_WIDTH)+1 bits wide.

## Test plan
- DATA_WIDTH=8, x=13, y=11, op=0 → result=143, mod_start high only in cycle 9, in_ready high again in cycle 10.
- x=255, y=255, op=0 → result=65025 (0x0FE01), result[16]=0; x=0, y=200 → result=0 with the full 8-cycle latency.
- x=200, y=100, op=1 → result=300 in cycle 1, mod_start for exactly one cycle, in_ready in cycle 2.
- Reset asserted in cycle 4 of a multiply → outputs return to reset values next cycle and no mod_start appears. A following 5×6 multiply gives 30.
- in_valid held high with alternating ops (add 3+4, then mul 3×4) → results 7 then 12. Mid-operation operand changes are ignored. Exactly one mod_start per operation.
- Chained with the reducer (modulant=7): 13×11 → reducer out=3, done asserted. result stays stable for the whole reduction.
